// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: multi-cycle signed BCD add/sub/mul/div sequencer.
// Schedule: LOAD (BCD->bin), EXEC, FIX (sign/errors), CONV (bin->BCD).
// Ports: clk_db, rst (async, active-high), start, op, a_digits, b_digits,
//   a_neg, b_neg -> busy, done, result_digits, result_neg, err_bad_digit,
//   err_div_zero, err_overflow.
// Option: define CALC_SEQ_ROUND_EN to round division half away from zero.
module calc_seq_ctrl #(
    parameter int NDIG = 7,
    parameter int BW   = 24
) (
    input  logic              clk_db,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [4*NDIG-1:0] a_digits,
    input  logic [4*NDIG-1:0] b_digits,
    input  logic              a_neg,
    input  logic              b_neg,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] result_digits,
    output logic              result_neg,
    output logic              err_bad_digit,
    output logic              err_div_zero,
    output logic              err_overflow
);

    localparam int DW = 4 * NDIG;
    localparam int PW = 2 * BW;
    localparam int CW = $clog2(BW + 1);
    localparam logic [PW-1:0] LIMIT = PW'(10 ** NDIG);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_FIX,
        S_CONV
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_q;
    logic [DW-1:0]   a_cap;
    logic [DW-1:0]   b_cap;
    logic            a_sgn;
    logic            b_sgn;
    logic [BW-1:0]   acc_a;
    logic [BW-1:0]   acc_b;
    logic [PW-1:0]   prod;
    logic [BW-1:0]   rem;
    logic            bad_q;
    logic            res_sgn;
    logic [BW-1:0]   bin;
    logic [DW-1:0]   bcd;
    logic            pend_neg;
    logic            pend_bad;
    logic            pend_dz;
    logic            pend_ovf;

    // Combinational helpers
    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [BW-1:0]   a_ld;
    logic [BW-1:0]   b_ld;
    logic            dig_bad;
    logic            b_eff;
    logic [BW:0]     as_mag;
    logic            as_neg;
    logic [PW-1:0]   mul_nxt;
    logic [BW:0]     trial;
    logic            q_bit;
    logic [BW-1:0]   rem_nxt;
    logic            fix_dz;
    logic [PW-1:0]   fix_mag;
    logic            fix_ovf;
    logic            fix_err;
    logic [DW-1:0]   adj;
    logic [DW-1:0]   bcd_nxt;
    logic [3:0]      nib;

    always_comb begin
        a_dig   = a_cap[4*int'(cnt) +: 4];
        b_dig   = b_cap[4*int'(cnt) +: 4];
        a_ld    = (acc_a << 3) + (acc_a << 1) + BW'(a_dig);
        b_ld    = (acc_b << 3) + (acc_b << 1) + BW'(b_dig);
        dig_bad = (a_dig > 4'd9) || (b_dig > 4'd9);
    end

    // Signed-magnitude add; subtraction flips B's sign first.
    always_comb begin
        b_eff = b_sgn ^ (op_q == OP_SUB);
        if (a_sgn == b_eff) begin
            as_mag = {1'b0, acc_a} + {1'b0, acc_b};
            as_neg = a_sgn;
        end else if (acc_a >= acc_b) begin
            as_mag = {1'b0, acc_a - acc_b};
            as_neg = a_sgn;
        end else begin
            as_mag = {1'b0, acc_b - acc_a};
            as_neg = b_eff;
        end
    end

    // Multiply consumes B MSB-first; divide shifts quotient bits into acc_a.
    always_comb begin
        mul_nxt = {prod[PW-2:0], 1'b0}
                + (acc_b[BW-1] ? PW'(acc_a) : '0);
        trial   = {rem, acc_a[BW-1]} - {1'b0, acc_b};
        q_bit   = ~trial[BW];
        rem_nxt = q_bit ? trial[BW-1:0]
                        : {rem[BW-2:0], acc_a[BW-1]};
    end

    always_comb begin
        fix_dz  = (op_q == OP_DIV) && (acc_b == '0);
        fix_mag = (op_q == OP_DIV) ? PW'(acc_a) : prod;
`ifdef CALC_SEQ_ROUND_EN
        if ((op_q == OP_DIV) && !fix_dz
            && ({rem, 1'b0} >= {1'b0, acc_b}))
            fix_mag = fix_mag + PW'(1);
`endif
        fix_ovf = fix_mag >= LIMIT;
        fix_err = bad_q || fix_dz || fix_ovf;
    end

    // Double-dabble step: add 3 to nibbles >= 5, then shift in next bit.
    always_comb begin
        adj = '0;
        nib = '0;
        for (int d = 0; d < NDIG; d++) begin
            nib = bcd[4*d +: 4];
            adj[4*d +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        bcd_nxt = {adj[DW-2:0], bin[BW-1]};
    end

    always_ff @(posedge clk_db or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            op_q          <= '0;
            a_cap         <= '0;
            b_cap         <= '0;
            a_sgn         <= 1'b0;
            b_sgn         <= 1'b0;
            acc_a         <= '0;
            acc_b         <= '0;
            prod          <= '0;
            rem           <= '0;
            bad_q         <= 1'b0;
            res_sgn       <= 1'b0;
            bin           <= '0;
            bcd           <= '0;
            pend_neg      <= 1'b0;
            pend_bad      <= 1'b0;
            pend_dz       <= 1'b0;
            pend_ovf      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result_digits <= '0;
            result_neg    <= 1'b0;
            err_bad_digit <= 1'b0;
            err_div_zero  <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_cap <= a_digits;
                        b_cap <= b_digits;
                        a_sgn <= a_neg;
                        b_sgn <= b_neg;
                        acc_a <= '0;
                        acc_b <= '0;
                        prod  <= '0;
                        rem   <= '0;
                        bad_q <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= CW'(NDIG - 1);
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    acc_a <= a_ld;
                    acc_b <= b_ld;
                    if (dig_bad)
                        bad_q <= 1'b1;
                    if (cnt == '0) begin
                        cnt   <= op_q[1] ? CW'(BW - 1) : '0;
                        state <= S_EXEC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_EXEC: begin
                    unique case (op_q)
                        OP_ADD, OP_SUB: begin
                            prod    <= PW'(as_mag);
                            res_sgn <= as_neg;
                        end
                        OP_MUL: begin
                            prod    <= mul_nxt;
                            acc_b   <= acc_b << 1;
                            res_sgn <= a_sgn ^ b_sgn;
                        end
                        default: begin
                            // Zero divisor: iterations skipped, slot count kept.
                            if (acc_b != '0) begin
                                acc_a <= {acc_a[BW-2:0], q_bit};
                                rem   <= rem_nxt;
                            end
                            res_sgn <= a_sgn ^ b_sgn;
                        end
                    endcase
                    if (cnt == '0)
                        state <= S_FIX;
                    else
                        cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    pend_bad <= bad_q;
                    pend_dz  <= !bad_q && fix_dz;
                    pend_ovf <= !bad_q && !fix_dz && fix_ovf;
                    bin      <= fix_err ? '0 : fix_mag[BW-1:0];
                    pend_neg <= (fix_err || fix_mag == '0) ? 1'b0 : res_sgn;
                    bcd      <= '0;
                    cnt      <= CW'(BW - 1);
                    state    <= S_CONV;
                end
                S_CONV: begin
                    bcd <= bcd_nxt;
                    bin <= bin << 1;
                    if (cnt == '0) begin
                        result_digits <= bcd_nxt;
                        result_neg    <= pend_neg;
                        err_bad_digit <= pend_bad;
                        err_div_zero  <= pend_dz;
                        err_overflow  <= pend_ovf;
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Multi-cycle arithmetic sequencer for the calculator.
- Accepts two 7-digit signed BCD integer operands and an operation code.
- Runs a fixed schedule: BCD-to-binary load, execute (add/sub single-cycle, shift-add multiply, restoring divide), sign/overflow fix-up, double-dabble binary-to-BCD.
- Sits between the input/state-machine logic and the display, replacing single-cycle wide arithmetic with a start/busy/done handshake.

Parameters:
NDIG, 7, number of BCD digits per operand and result
BW, 24, binary magnitude width; 10^NDIG <= 2^BW is required

Ports:
clk_db  in  1  system/debounce-domain clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  0=add, 1=sub, 2=mul, 3=div
a_digits  in  4*NDIG  operand A BCD, digit 0 in bits [3:0]
b_digits  in  4*NDIG  operand B BCD
a_neg  in  1  operand A sign
b_neg  in  1  operand B sign
busy  out  1  high while an operation is in flight
done  out  1  one-cycle pulse when results update
result_digits  out  4*NDIG  result magnitude, BCD
result_neg  out  1  result sign
err_bad_digit  out  1  an input nibble was >9
err_div_zero  out  1  divide with B magnitude 0
err_overflow  out  1  result magnitude >= 10^NDIG

Behaviour:
- Clock/reset: one clock (clk_db); reset is asynchronous, active-high (rst). Reset forces IDLE. All outputs, counters and datapath registers reset to 0. Reset mid-operation aborts; no done pulse.
- States: IDLE, LOAD, EXEC, FIX, CONV.
- IDLE:
  - start=1 at edge N: capture op, both digit vectors and signs; busy<=1; cnt<=NDIG-1; go to LOAD.
  - start while busy is ignored; it is not queued.
- LOAD, NDIG cycles (edges N+1..N+NDIG):
  - accA<=accA*10+a_digit[cnt], same for accB, MSD first.
  - Any nibble >9 latches a bad-digit flag; the schedule still runs to completion.
- EXEC, E cycles (E=1 for add/sub, E=BW for mul/div):
  - Add/sub: signed-magnitude add in BW+1 bits. Sub negates B's sign. Result sign follows the larger magnitude.
  - Mul: BW-step shift-add into a 2*BW product; sign = a_neg^b_neg.
  - Div: BW-step restoring division, quotient BW bits plus remainder; truncates toward zero; sign = a_neg^b_neg. If B=0, set div-zero and skip iterations (still BW cycles, quotient 0).
- FIX, 1 cycle:
  - Overflow if magnitude >= 10^NDIG.
  - Error priority: bad_digit > div_zero > overflow. Only the highest error flag is set.
  - Any error forces magnitude 0 and sign 0.
  - A zero magnitude always forces sign 0 (no -0).
- CONV, BW cycles: double-dabble (add-3 on nibbles >=5, then shift) over BW bits into 4*NDIG BCD.
- Completion at edge N+NDIG+E+BW+1 (add/sub N+33, mul/div N+56 at defaults):
  - result_digits, result_neg and error flags update.
  - done=1 for exactly one cycle; busy<=0; return to IDLE.
  - start sampled high on the cycle after done starts a new operation.
- Outputs hold their values between done pulses. Errors clear only on the next completion or on reset.

Optional Feature:
CALC_SEQ_ROUND_EN
- Defined: in FIX, division rounds half away from zero. If 2*remainder >= |B| then magnitude+1 (overflow rechecked). Latency unchanged.
- Undefined: division truncates toward zero. No FIX adder is generated.

Test Plan:
- A=123, B=456, op=add, start at edge N -> busy high at N..N+32; done at N+33; result 0000579, neg=0, no errors.
- A=5, B=12, op=sub -> result 0000007, neg=1; second start pulsed during busy is ignored (exactly one done).
- A=1234, B=5678, op=mul -> done at N+56; result 7006652, neg=0. Then A=9999999, B=2, op=mul -> err_overflow=1, result 0, neg=0.
- A=7, B=0, op=div -> err_div_zero=1, result 0. Then A=7 with nibble 0xA at digit 3, op=div, B=0 -> only err_bad_digit=1.
- A=-7, B=2, op=div -> result 3, neg=1. With CALC_SEQ_ROUND_EN -> result 4, neg=1. A=-0, B=5, op=mul -> result 0, neg=0.
- rst asserted at N+20 of a mul -> outputs 0 immediately, no done; next start completes normally with correct result.
